bt_cmd_ctrl: RTL and testbench

Parametrised Bluetooth command controller for the MP3 player: receives 8N1 UART bytes from the Bluetooth module, decodes single- and two-byte commands, and keeps the player control state: volume, song index, and pause. It also turns decoder end-of-track into auto-advance. It sits between the BT module's rx pin and the playback/VS10xx control logic. It generalises the previous fixed controller with parametric baud, clock, song count, index width, volume step, a direct song-jump command and framing-error reporting.

---
 rtl/bt_cmd_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_bt_cmd_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_cmd_ctrl.sv
// Bluetooth command controller for the MP3 player.
// Receives 8N1 UART bytes from the BT module, decodes single-byte commands
// ('N' next, 'P' prev, 'S' pause toggle, '+'/'-' volume) and the two-byte
// 'G' <index> song jump, and keeps volume, song index and pause state.
// A rising edge on i_FINISH auto-advances to the next song.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   rx            UART line from BT module (idle high, asynchronous)
//   i_FINISH      end-of-track from playback, edge-detected
//   o_vol         {att, att} left/right attenuation, 0x00 loudest
//   o_song_select current song index
//   o_next        one-cycle pulse on forward change or jump
//   o_pre         one-cycle pulse on backward change
//   o_pause       1 = paused
//   o_frame_err   one-cycle pulse when a byte is dropped for a low stop bit
module bt_cmd_ctrl #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned SONG_NUM = 2,
  parameter int unsigned SEL_W    = 5,
  parameter logic [7:0]  VOL_INIT = 8'h40,
  parameter logic [7:0]  VOL_STEP = 8'h10,
  parameter logic [7:0]  VOL_MAX  = 8'hFE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             i_FINISH,
  output logic [15:0]      o_vol,
  output logic [SEL_W-1:0] o_song_select,
  output logic             o_next,
  output logic             o_pre,
  output logic             o_pause,
  output logic             o_frame_err
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam logic [CntW-1:0]  CntFull  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0]  CntHalf  = CntW'(ClksPerBit / 2 - 1);
  localparam logic [SEL_W-1:0] LastSong = SEL_W'(SONG_NUM - 1);

  localparam logic [7:0] ChNext  = 8'h4E;
  localparam logic [7:0] ChPrev  = 8'h50;
  localparam logic [7:0] ChPause = 8'h53;
  localparam logic [7:0] ChVolUp = 8'h2B;
  localparam logic [7:0] ChVolDn = 8'h2D;
  localparam logic [7:0] ChGoto  = 8'h47;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;
  typedef enum logic {PsCmd, PsArg} parse_st_e;

  logic            rx_meta_q, rx_sync_q;
  uart_st_e        uart_st_q, uart_st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_vld_q, byte_vld_d;
  logic            frame_err_q, frame_err_d;
  logic            fin_prev_q, fin_edge_q;

  parse_st_e       parse_q, parse_d;
  logic [7:0]      vol_q, vol_d;
  logic [SEL_W-1:0] song_q, song_d;
  logic            next_q, next_d;
  logic            pre_q, pre_d;
  logic            pause_q, pause_d;
  logic            song_cmd;
  logic [8:0]      vol_sum;

  // UART receiver: all timing is taken from mid-bit of the start bit.
  always_comb begin
    uart_st_d   = uart_st_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (uart_st_q)
      StIdle: begin
        if (!rx_sync_q) begin
          uart_st_d = StStart;
          cnt_d     = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d     = '0;
          bit_d     = '0;
          // Line back high at mid start bit: treat as a glitch.
          uart_st_d = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) uart_st_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d       = '0;
          byte_vld_d  = rx_sync_q;
          frame_err_d = ~rx_sync_q;
          uart_st_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: uart_st_d = StIdle;
    endcase
  end

  // Command parser and player state.
  always_comb begin
    parse_d  = parse_q;
    vol_d    = vol_q;
    song_d   = song_q;
    pause_d  = pause_q;
    next_d   = 1'b0;
    pre_d    = 1'b0;
    song_cmd = 1'b0;
    vol_sum  = {1'b0, vol_q} + {1'b0, VOL_STEP};
    if (byte_vld_q) begin
      if (parse_q == PsCmd) begin
        unique case (shift_q)
          ChNext: begin
            song_d   = (song_q == LastSong) ? '0 : song_q + SEL_W'(1);
            next_d   = 1'b1;
            pause_d  = 1'b0;
            song_cmd = 1'b1;
          end
          ChPrev: begin
            song_d   = (song_q == '0) ? LastSong : song_q - SEL_W'(1);
            pre_d    = 1'b1;
            pause_d  = 1'b0;
            song_cmd = 1'b1;
          end
          ChPause: pause_d = ~pause_q;
          ChVolUp: vol_d = (vol_q >= VOL_STEP) ? vol_q - VOL_STEP : 8'h00;
          ChVolDn: vol_d = (vol_sum > {1'b0, VOL_MAX}) ? VOL_MAX : vol_sum[7:0];
          ChGoto:  parse_d = PsArg;
          default: ;
        endcase
      end else begin
        parse_d = PsCmd;
        if (32'(shift_q) < SONG_NUM) begin
          song_d   = SEL_W'(shift_q);
          next_d   = 1'b1;
          pause_d  = 1'b0;
          song_cmd = 1'b1;
        end
      end
    end
    if (frame_err_q) parse_d = PsCmd;
    // A song-changing command in the same cycle swallows the finish edge;
    // otherwise the advance applies and its pause clear beats an 'S' toggle.
    if (fin_edge_q && !song_cmd) begin
      song_d  = (song_q == LastSong) ? '0 : song_q + SEL_W'(1);
      next_d  = 1'b1;
      pause_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      uart_st_q   <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      fin_prev_q  <= 1'b0;
      fin_edge_q  <= 1'b0;
      parse_q     <= PsCmd;
      vol_q       <= VOL_INIT;
      song_q      <= '0;
      next_q      <= 1'b0;
      pre_q       <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      uart_st_q   <= uart_st_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      fin_prev_q  <= i_FINISH;
      fin_edge_q  <= i_FINISH & ~fin_prev_q;
      parse_q     <= parse_d;
      vol_q       <= vol_d;
      song_q      <= song_d;
      next_q      <= next_d;
      pre_q       <= pre_d;
      pause_q     <= pause_d;
    end
  end

  assign o_vol         = {vol_q, vol_q};
  assign o_song_select = song_q;
  assign o_next        = next_q;
  assign o_pre         = pre_q;
  assign o_pause       = pause_q;
  assign o_frame_err   = frame_err_q;

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Bench for bt_cmd_ctrl: directed UART bytes and i_FINISH stimulus, a
// cycle-level event model of the player state, and literal spot checks.
module tb_bt_cmd_ctrl;

  localparam int CPB = 10;
  localparam int SN  = 4;
  // Start-bit drive edge to visible output change.
  localparam int LAT = 2 + (19 * CPB) / 2 + 2;

  typedef struct {
    int         at;
    logic [7:0] b;
    bit         ferr;
  } byte_ev_t;

  logic        clk, rst, rx, i_finish;
  logic [15:0] o_vol;
  logic [4:0]  o_song_select;
  logic        o_next, o_pre, o_pause, o_frame_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic rst_s = 1'b0;

  byte_ev_t byte_q[$];
  int       fin_q[$];
  int       next_cnt = 0, pre_cnt = 0, ferr_cnt = 0;

  bt_cmd_ctrl #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000),
    .SONG_NUM(SN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .i_FINISH     (i_finish),
    .o_vol        (o_vol),
    .o_song_select(o_song_select),
    .o_next       (o_next),
    .o_pre        (o_pre),
    .o_pause      (o_pause),
    .o_frame_err  (o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Per-cycle model: applies scheduled byte / finish events, then compares.
  task automatic monitor();
    int  m_vol = 8'h40, m_idx = 0;
    bit  m_pause = 0, m_arg = 0, armed = 0;
    bit  e_next, e_pre, e_fe, song_chg, has_b, has_f;
    byte_ev_t ev;
    forever begin
      @(negedge clk);
      e_next = 0; e_pre = 0; e_fe = 0; song_chg = 0;
      if (rst_s) begin
        m_vol = 8'h40; m_idx = 0; m_pause = 0; m_arg = 0; armed = 1;
        byte_q.delete();
        fin_q.delete();
      end else if (armed) begin
        has_b = 0; has_f = 0;
        for (int i = byte_q.size() - 1; i >= 0; i--)
          if (byte_q[i].at == cyc) begin ev = byte_q[i]; has_b = 1; byte_q.delete(i); end
        for (int i = fin_q.size() - 1; i >= 0; i--)
          if (fin_q[i] == cyc) begin has_f = 1; fin_q.delete(i); end
        if (has_b && ev.ferr) begin
          e_fe = 1; m_arg = 0;
        end else if (has_b && !m_arg) begin
          case (ev.b)
            8'h4E: begin m_idx = (m_idx + 1) % SN; e_next = 1; m_pause = 0; song_chg = 1; end
            8'h50: begin m_idx = (m_idx + SN - 1) % SN; e_pre = 1; m_pause = 0; song_chg = 1; end
            8'h53: m_pause = !m_pause;
            8'h2B: m_vol = (m_vol >= 16) ? m_vol - 16 : 0;
            8'h2D: m_vol = (m_vol + 16 > 254) ? 254 : m_vol + 16;
            8'h47: m_arg = 1;
            default: ;
          endcase
        end else if (has_b) begin
          m_arg = 0;
          if (int'(ev.b) < SN) begin
            m_idx = int'(ev.b); e_next = 1; m_pause = 0; song_chg = 1;
          end
        end
        if (has_f && !song_chg) begin
          m_idx = (m_idx + 1) % SN; e_next = 1; m_pause = 0;
        end
      end
      if (armed) begin
        next_cnt += int'(o_next);
        pre_cnt  += int'(o_pre);
        ferr_cnt += int'(o_frame_err);
        checks++;
        if (o_vol !== {m_vol[7:0], m_vol[7:0]} || o_song_select !== 5'(m_idx) ||
            o_next !== e_next || o_pre !== e_pre || o_pause !== m_pause ||
            o_frame_err !== e_fe) begin
          errors++;
          $display("FAIL model cyc %0d: got vol=%h song=%0d nx=%b pr=%b pa=%b fe=%b want vol=%h song=%0d nx=%b pr=%b pa=%b fe=%b",
                   cyc, o_vol, o_song_select, o_next, o_pre, o_pause, o_frame_err,
                   {m_vol[7:0], m_vol[7:0]}, m_idx, e_next, e_pre, m_pause, e_fe);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    byte_ev_t ev;
    @(posedge clk); #1;
    ev.b    = b;
    ev.ferr = !stop_bit;
    ev.at   = stop_bit ? cyc + LAT : cyc + LAT - 1;
    byte_q.push_back(ev);
    rx = 1'b0;
    repeat (CPB) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk); #1;
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk); #1;
    rx = 1'b1;
  endtask

  task automatic set_fin(input logic v);
    if (v && !i_finish) fin_q.push_back(cyc + 2);
    i_finish = v;
  endtask

  initial begin
    int n0, p0;
    logic [15:0] vol_exp [4];
    rst = 1'b1; rx = 1'b1; i_finish = 1'b0;
    vol_exp[0] = 16'h3030; vol_exp[1] = 16'h2020; vol_exp[2] = 16'h1010; vol_exp[3] = 16'h0000;
    fork monitor(); join_none
    repeat (4) @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset vol", 32'(o_vol), 32'h4040);
    check("reset song", 32'(o_song_select), 0);
    check("reset pause", 32'(o_pause), 0);
    check("reset pulses", {29'd0, o_next, o_pre, o_frame_err}, 0);

    for (int i = 1; i <= 4; i++) begin
      send_byte(8'h4E, 1'b1);
      check("next index", 32'(o_song_select), 32'(i % 4));
    end
    check("next pulses", next_cnt, 4);
    check("no prev pulses", pre_cnt, 0);

    send_byte(8'h50, 1'b1);
    check("prev wrap", 32'(o_song_select), 3);
    check("prev pulse", pre_cnt, 1);
    send_byte(8'h47, 1'b1); send_byte(8'h02, 1'b1);
    check("jump 2", 32'(o_song_select), 2);
    check("jump pulse", next_cnt, 5);
    send_byte(8'h47, 1'b1); send_byte(8'h07, 1'b1);
    check("jump oob", 32'(o_song_select), 2);
    check("jump oob no pulse", next_cnt, 5);
    send_byte(8'h4E, 1'b1);
    check("next after oob", 32'(o_song_select), 3);

    send_byte(8'h53, 1'b1); check("pause on", 32'(o_pause), 1);
    send_byte(8'h53, 1'b1); check("pause off", 32'(o_pause), 0);
    send_byte(8'h53, 1'b1); send_byte(8'h4E, 1'b1);
    check("next clears pause", 32'(o_pause), 0);
    check("next after pause", 32'(o_song_select), 0);

    for (int i = 0; i < 5; i++) begin
      send_byte(8'h2B, 1'b1);
      check("vol up", 32'(o_vol), 32'(vol_exp[(i < 4) ? i : 3]));
    end
    for (int i = 0; i < 16; i++) send_byte(8'h2D, 1'b1);
    check("vol down sat", 32'(o_vol), 32'hFEFE);

    n0 = next_cnt;
    @(posedge clk); #1 set_fin(1'b1);
    repeat (50) @(posedge clk);
    #1 set_fin(1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("finish once", next_cnt - n0, 1);
    check("finish index", 32'(o_song_select), 1);

    n0 = next_cnt; p0 = pre_cnt;
    fork
      send_byte(8'h50, 1'b1);
      begin repeat (98) @(posedge clk); #1 set_fin(1'b1); end
    join
    set_fin(1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("collide index", 32'(o_song_select), 0);
    check("collide no next", next_cnt - n0, 0);
    check("collide prev", pre_cnt - p0, 1);

    send_byte(8'h4E, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("frame err pulse", ferr_cnt, 1);
    check("frame err index", 32'(o_song_select), 0);

    n0 = next_cnt;
    @(posedge clk); #1 rx = 1'b0;
    repeat (2) @(posedge clk); #1 rx = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("glitch no byte", next_cnt - n0, 0);
    check("glitch no ferr", ferr_cnt, 1);

    send_byte(8'h53, 1'b1);
    send_byte(8'h47, 1'b1);
    @(posedge clk); #1 rx = 1'b0;
    repeat (35) @(posedge clk); #1;
    rx = 1'b1; rst = 1'b1;
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("mid reset vol", 32'(o_vol), 32'h4040);
    check("mid reset song", 32'(o_song_select), 0);
    check("mid reset pause", 32'(o_pause), 0);
    send_byte(8'h02, 1'b1);
    check("parser back in cmd", 32'(o_song_select), 0);
    send_byte(8'h4E, 1'b1);
    check("next after reset", 32'(o_song_select), 1);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
